// File: rtl/core_exc_ctrl.sv
// Exception/interrupt controller: fixed-priority entry, nested {EPC,ESR} stack, rfe, SPRs, double-fault lock-up.
// Latency: redirect/flush/mode/SR-restore are combinational (0 cycles); irq_ack and stack/DEPTH update 1 cycle.
// Backpressure: i_mau_busy halts all stages and freezes entry/rfe/SPR writes; sources must hold their strobes.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_irq / o_irq_ack              edge-latched interrupt lines / one-cycle one-hot acknowledge
//   i_swi, i_if_err, i_id_err,
//   i_mau_err, i_rfe, i_mau_busy   event strobes from the pipeline
//   i_if_pc, i_id_pc, i_ex_pc      stage PCs (EPC sources)
//   i_sr                           current status register, bit 0 = global interrupt enable
//   i_wb_spr, i_spr_addr,
//   i_spr_wdata, o_spr_rdata       SPR write port / combinational read port
//   o_set_pc, o_new_pc             PC redirect
//   o_mode, o_write_mode           exception code and its write strobe
//   o_write_sr, o_wb_sr            SR write strobe and data
//   o_id_flush, o_ex_flush,
//   o_if_halt, o_id_halt,
//   o_ex_halt, o_fatal             stage controls and terminal-fault flag
`timescale 1ns/1ps
module core_exc_ctrl #(
  parameter int          NIRQ       = 8,
  parameter int          EDEPTH     = 4,
  parameter int          AW         = 32,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int          VEC_STRIDE = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NIRQ-1:0] i_irq,
  output logic [NIRQ-1:0] o_irq_ack,
  input  logic            i_swi,
  input  logic            i_if_err,
  input  logic            i_id_err,
  input  logic            i_mau_err,
  input  logic            i_rfe,
  input  logic            i_mau_busy,
  input  logic [AW-1:0]   i_if_pc,
  input  logic [AW-1:0]   i_id_pc,
  input  logic [AW-1:0]   i_ex_pc,
  input  logic [AW-1:0]   i_sr,
  input  logic            i_wb_spr,
  input  logic [4:0]      i_spr_addr,
  input  logic [AW-1:0]   i_spr_wdata,
  output logic [AW-1:0]   o_spr_rdata,
  output logic            o_set_pc,
  output logic [AW-1:0]   o_new_pc,
  output logic [3:0]      o_mode,
  output logic            o_write_mode,
  output logic            o_write_sr,
  output logic [AW-1:0]   o_wb_sr,
  output logic            o_id_flush,
  output logic            o_ex_flush,
  output logic            o_if_halt,
  output logic            o_id_halt,
  output logic            o_ex_halt,
  output logic            o_fatal
);

  localparam int DW = $clog2(EDEPTH + 1);
  localparam int IW = $clog2(EDEPTH);
  localparam logic [AW-1:0] LP_BASE   = AW'(VEC_BASE);
  localparam logic [AW-1:0] LP_STRIDE = AW'(VEC_STRIDE);

  localparam logic [4:0] C_SWI    = 5'd1;
  localparam logic [4:0] C_IFERR  = 5'd2;
  localparam logic [4:0] C_IDERR  = 5'd3;
  localparam logic [4:0] C_MAUERR = 5'd4;
  localparam logic [4:0] C_DFAULT = 5'd5;

  typedef enum logic [1:0] {ST_RUN, ST_LOCK, ST_FATAL} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_depth;
  logic [AW-1:0]   r_epc [EDEPTH];
  logic [AW-1:0]   r_esr [EDEPTH];
  logic [NIRQ-1:0] r_imask;
  logic [NIRQ-1:0] r_ipend;
  logic [NIRQ-1:0] r_irq_prev;
  logic [NIRQ-1:0] r_irq_ack;

  logic [NIRQ-1:0] w_irq_elig;
  logic            w_irq_hit;
  logic [NIRQ-1:0] w_irq_oh;
  logic [4:0]      w_irq_code;
  logic [IW-1:0]   w_top;
  logic [AW-1:0]   w_top_epc;
  logic [AW-1:0]   w_top_esr;
  logic            w_empty;
  logic            w_full;

  logic            w_src;
  logic [4:0]      w_code;
  logic [AW-1:0]   w_epc;
  logic            w_push;
  logic            w_pop;
  logic            w_spr_we;
  logic [NIRQ-1:0] w_ack_set;

  assign w_irq_elig = r_ipend & r_imask;
  assign w_empty    = (r_depth == '0);
  assign w_full     = (r_depth == DW'(EDEPTH));
  assign w_top      = IW'(r_depth - DW'(1));
  assign w_top_epc  = w_empty ? '0 : r_epc[w_top];
  assign w_top_esr  = w_empty ? '0 : r_esr[w_top];
  assign o_irq_ack  = r_irq_ack;

  // Lowest eligible index wins: scan downward so the last hit is the lowest.
  always_comb begin
    w_irq_hit  = 1'b0;
    w_irq_oh   = '0;
    w_irq_code = 5'd0;
    for (int k = NIRQ - 1; k >= 0; k--) begin
      if (w_irq_elig[k]) begin
        w_irq_hit   = 1'b1;
        w_irq_oh    = '0;
        w_irq_oh[k] = 1'b1;
        w_irq_code  = 5'(8 + k);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = (r_state == ST_LOCK) ? ST_RUN : r_state;
    w_src        = 1'b0;
    w_code       = 5'd0;
    w_epc        = '0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_spr_we     = 1'b0;
    w_ack_set    = '0;
    o_set_pc     = 1'b0;
    o_new_pc     = '0;
    o_mode       = 4'd0;
    o_write_mode = 1'b0;
    o_write_sr   = 1'b0;
    o_wb_sr      = '0;
    o_id_flush   = 1'b0;
    o_ex_flush   = 1'b0;
    o_if_halt    = 1'b0;
    o_id_halt    = 1'b0;
    o_ex_halt    = 1'b0;
    o_fatal      = 1'b0;

    if (r_state == ST_FATAL) begin
      o_if_halt = 1'b1;
      o_id_halt = 1'b1;
      o_ex_halt = 1'b1;
      o_fatal   = 1'b1;
    end else if (i_mau_busy) begin
      o_if_halt = 1'b1;
      o_id_halt = 1'b1;
      o_ex_halt = 1'b1;
    end else begin
      // An rfe with nothing to return to is an illegal instruction, hence IDERR.
      if (i_mau_err) begin
        w_src = 1'b1; w_code = C_MAUERR; w_epc = i_ex_pc;
      end else if (i_id_err || (i_rfe && w_empty)) begin
        w_src = 1'b1; w_code = C_IDERR;  w_epc = i_id_pc;
      end else if (i_if_err) begin
        w_src = 1'b1; w_code = C_IFERR;  w_epc = i_if_pc;
      end else if (i_swi) begin
        w_src = 1'b1; w_code = C_SWI;    w_epc = i_id_pc;
      end else if (w_irq_hit && i_sr[0] && (r_state == ST_RUN)) begin
        w_src = 1'b1; w_code = w_irq_code; w_epc = i_id_pc;
        w_ack_set = w_irq_oh;
      end

      if (w_src) begin
        o_set_pc     = 1'b1;
        o_write_mode = 1'b1;
        o_id_flush   = 1'b1;
        if (w_full) begin
          // Double fault: redirect once, nothing pushed, interrupt not acknowledged.
          w_code      = C_DFAULT;
          w_ack_set   = '0;
          o_ex_flush  = 1'b1;
          w_state_nxt = ST_FATAL;
        end else begin
          o_ex_flush  = (w_code != C_IFERR);
          w_push      = 1'b1;
          w_state_nxt = ST_LOCK;
        end
        o_mode   = w_code[3:0];
        o_new_pc = LP_BASE + AW'(w_code) * LP_STRIDE;
      end else if (i_rfe) begin
        o_set_pc   = 1'b1;
        o_new_pc   = w_top_epc;
        o_write_sr = 1'b1;
        o_wb_sr    = w_top_esr;
        w_pop      = 1'b1;
      end else if (i_wb_spr) begin
        w_spr_we = 1'b1;
        if (i_spr_addr == 5'd0) begin
          o_write_sr = 1'b1;
          o_wb_sr    = i_spr_wdata;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_depth    <= '0;
      r_imask    <= '0;
      r_ipend    <= '0;
      r_irq_prev <= '0;
      r_irq_ack  <= '0;
      for (int i = 0; i < EDEPTH; i++) begin
        r_epc[i] <= '0;
        r_esr[i] <= '0;
      end
    end else begin
      r_irq_prev <= i_irq;
      r_irq_ack  <= w_ack_set;
      // A new edge in the same cycle as the ack keeps the line pending.
      r_ipend    <= (r_ipend & ~w_ack_set) | (i_irq & ~r_irq_prev);
      if (w_push) begin
        r_epc[IW'(r_depth)] <= w_epc;
        r_esr[IW'(r_depth)] <= i_sr;
        r_depth             <= r_depth + DW'(1);
      end else if (w_pop) begin
        r_depth <= r_depth - DW'(1);
      end else if (w_spr_we) begin
        case (i_spr_addr)
          5'd1:    if (!w_empty) r_epc[w_top] <= i_spr_wdata;
          5'd2:    if (!w_empty) r_esr[w_top] <= i_spr_wdata;
          5'd3:    r_imask <= i_spr_wdata[NIRQ-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_spr_rdata = '0;
    case (i_spr_addr)
      5'd0:    o_spr_rdata = i_sr;
      5'd1:    o_spr_rdata = w_top_epc;
      5'd2:    o_spr_rdata = w_top_esr;
      5'd3:    o_spr_rdata = AW'(r_imask);
      5'd4:    o_spr_rdata = AW'(r_ipend);
      5'd5:    o_spr_rdata = AW'(r_depth);
      default: o_spr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_core_exc_ctrl.sv
`timescale 1ns/1ps
module tb_core_exc_ctrl;
  localparam int NIRQ = 8;
  localparam int AW   = 32;

  logic            clk, rst_n;
  logic [NIRQ-1:0] irq, irq_ack;
  logic            swi, if_err, id_err, mau_err, rfe, mau_busy;
  logic [AW-1:0]   if_pc, id_pc, ex_pc, sr;
  logic            wb_spr;
  logic [4:0]      spr_addr;
  logic [AW-1:0]   spr_wdata, spr_rdata;
  logic            set_pc;
  logic [AW-1:0]   new_pc;
  logic [3:0]      mode;
  logic            write_mode, write_sr;
  logic [AW-1:0]   wb_sr;
  logic            id_flush, ex_flush, if_halt, id_halt, ex_halt, fatal;

  int tests;
  int fails;

  core_exc_ctrl #(.NIRQ(NIRQ), .EDEPTH(4), .AW(AW), .VEC_BASE(32'h0000_0100), .VEC_STRIDE(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_irq(irq), .o_irq_ack(irq_ack),
    .i_swi(swi), .i_if_err(if_err), .i_id_err(id_err), .i_mau_err(mau_err),
    .i_rfe(rfe), .i_mau_busy(mau_busy),
    .i_if_pc(if_pc), .i_id_pc(id_pc), .i_ex_pc(ex_pc), .i_sr(sr),
    .i_wb_spr(wb_spr), .i_spr_addr(spr_addr), .i_spr_wdata(spr_wdata), .o_spr_rdata(spr_rdata),
    .o_set_pc(set_pc), .o_new_pc(new_pc), .o_mode(mode), .o_write_mode(write_mode),
    .o_write_sr(write_sr), .o_wb_sr(wb_sr),
    .o_id_flush(id_flush), .o_ex_flush(ex_flush),
    .o_if_halt(if_halt), .o_id_halt(id_halt), .o_ex_halt(ex_halt), .o_fatal(fatal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    irq = '0; swi = 0; if_err = 0; id_err = 0; mau_err = 0; rfe = 0; mau_busy = 0;
    if_pc = '0; id_pc = '0; ex_pc = '0; sr = '0;
    wb_spr = 0; spr_addr = 5'd0; spr_wdata = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    spr_addr = 5'd5;
    #12;
    tests++; if (set_pc !== 1'b0) begin fails++; $display("FAIL rst_set_pc got %b exp 0", set_pc); end
    tests++; if (new_pc !== 32'h0) begin fails++; $display("FAIL rst_new_pc got %h exp 0", new_pc); end
    tests++; if (irq_ack !== 8'h00) begin fails++; $display("FAIL rst_irq_ack got %h exp 00", irq_ack); end
    tests++; if ({fatal, if_halt, id_halt, ex_halt} !== 4'b0000) begin fails++; $display("FAIL rst_fatal_halts got %b exp 0000", {fatal, if_halt, id_halt, ex_halt}); end
    tests++; if (spr_rdata !== 32'h0) begin fails++; $display("FAIL rst_depth got %h exp 0", spr_rdata); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_irq_single();
    @(negedge clk); wb_spr = 1; spr_addr = 5'd3; spr_wdata = 32'h08; sr = 32'h1; id_pc = 32'h200;
    @(negedge clk); wb_spr = 0; irq = 8'h08; #1;
    tests++; if (spr_rdata !== 32'h08) begin fails++; $display("FAIL imask_rd got %h exp 08", spr_rdata); end
    tests++; if (set_pc !== 1'b0) begin fails++; $display("FAIL irq3_early got %b exp 0", set_pc); end
    @(negedge clk); #1;
    tests++; if (set_pc !== 1'b1) begin fails++; $display("FAIL irq3_set_pc got %b exp 1", set_pc); end
    tests++; if (new_pc !== 32'h1B0) begin fails++; $display("FAIL irq3_pc got %h exp 1b0", new_pc); end
    tests++; if (mode !== 4'd11 || write_mode !== 1'b1) begin fails++; $display("FAIL irq3_mode got %0d/%b exp 11/1", mode, write_mode); end
    tests++; if ({id_flush, ex_flush} !== 2'b11) begin fails++; $display("FAIL irq3_flush got %b exp 11", {id_flush, ex_flush}); end
    tests++; if (irq_ack !== 8'h00) begin fails++; $display("FAIL irq3_ack_early got %h exp 00", irq_ack); end
    @(negedge clk); spr_addr = 5'd5; #1;
    tests++; if (irq_ack !== 8'h08) begin fails++; $display("FAIL irq3_ack got %h exp 08", irq_ack); end
    tests++; if (spr_rdata !== 32'h1) begin fails++; $display("FAIL irq3_depth got %h exp 1", spr_rdata); end
    tests++; if (set_pc !== 1'b0) begin fails++; $display("FAIL irq3_retake got %b exp 0", set_pc); end
    @(negedge clk); spr_addr = 5'd1; #1;
    tests++; if (irq_ack !== 8'h00) begin fails++; $display("FAIL irq3_ack_len got %h exp 00", irq_ack); end
    tests++; if (spr_rdata !== 32'h200) begin fails++; $display("FAIL irq3_epc got %h exp 200", spr_rdata); end
    @(negedge clk); irq = '0; rfe = 1; sr = 32'h0; #1;
    tests++; if (new_pc !== 32'h200 || set_pc !== 1'b1) begin fails++; $display("FAIL rfe1_pc got %h/%b exp 200/1", new_pc, set_pc); end
    tests++; if (wb_sr !== 32'h1 || write_sr !== 1'b1) begin fails++; $display("FAIL rfe1_sr got %h/%b exp 1/1", wb_sr, write_sr); end
    @(negedge clk); rfe = 0; sr = 32'h1; spr_addr = 5'd5; #1;
    tests++; if (spr_rdata !== 32'h0) begin fails++; $display("FAIL rfe1_depth got %h exp 0", spr_rdata); end
  endtask

  task automatic test_irq_nested();
    @(negedge clk); wb_spr = 1; spr_addr = 5'd3; spr_wdata = 32'h22;
    @(negedge clk); wb_spr = 0; irq = 8'h22; id_pc = 32'h300; #1;
    tests++; if (set_pc !== 1'b0) begin fails++; $display("FAIL nest_early got %b exp 0", set_pc); end
    @(negedge clk); #1;
    tests++; if (set_pc !== 1'b1 || new_pc !== 32'h190 || mode !== 4'd9) begin fails++; $display("FAIL nest_irq1 got %b/%h/%0d exp 1/190/9", set_pc, new_pc, mode); end
    @(negedge clk); id_pc = 32'h304; #1;
    tests++; if (set_pc !== 1'b0) begin fails++; $display("FAIL nest_lock got %b exp 0", set_pc); end
    tests++; if (irq_ack !== 8'h02) begin fails++; $display("FAIL nest_ack1 got %h exp 02", irq_ack); end
    @(negedge clk); #1;
    tests++; if (set_pc !== 1'b1 || new_pc !== 32'h1D0 || mode !== 4'd13) begin fails++; $display("FAIL nest_irq5 got %b/%h/%0d exp 1/1d0/13", set_pc, new_pc, mode); end
    @(negedge clk); spr_addr = 5'd5; #1;
    tests++; if (irq_ack !== 8'h20) begin fails++; $display("FAIL nest_ack5 got %h exp 20", irq_ack); end
    tests++; if (spr_rdata !== 32'h2) begin fails++; $display("FAIL nest_depth got %h exp 2", spr_rdata); end
    @(negedge clk); rfe = 1; #1;
    tests++; if (new_pc !== 32'h304) begin fails++; $display("FAIL nest_rfe_a got %h exp 304", new_pc); end
    @(negedge clk); #1;
    tests++; if (new_pc !== 32'h300) begin fails++; $display("FAIL nest_rfe_b got %h exp 300", new_pc); end
    @(negedge clk); rfe = 0; irq = '0; #1;
    tests++; if (spr_rdata !== 32'h0) begin fails++; $display("FAIL nest_depth0 got %h exp 0", spr_rdata); end
  endtask

  task automatic test_mau_swi();
    @(negedge clk); sr = 32'h5; ex_pc = 32'h400; id_pc = 32'h404; mau_err = 1; swi = 1; #1;
    tests++; if (set_pc !== 1'b1 || new_pc !== 32'h140 || mode !== 4'd4) begin fails++; $display("FAIL mau_entry got %b/%h/%0d exp 1/140/4", set_pc, new_pc, mode); end
    tests++; if (ex_flush !== 1'b1) begin fails++; $display("FAIL mau_exflush got %b exp 1", ex_flush); end
    @(negedge clk); mau_err = 0; swi = 0; sr = 32'h1; spr_addr = 5'd1; #1;
    tests++; if (spr_rdata !== 32'h400) begin fails++; $display("FAIL mau_epc got %h exp 400", spr_rdata); end
    tests++; if (set_pc !== 1'b0) begin fails++; $display("FAIL mau_swi_dropped got %b exp 0", set_pc); end
    @(negedge clk); spr_addr = 5'd2; #1;
    tests++; if (spr_rdata !== 32'h5) begin fails++; $display("FAIL mau_esr got %h exp 5", spr_rdata); end
    @(negedge clk); rfe = 1; #1;
    tests++; if (new_pc !== 32'h400 || wb_sr !== 32'h5 || write_sr !== 1'b1) begin fails++; $display("FAIL mau_rfe got %h/%h/%b exp 400/5/1", new_pc, wb_sr, write_sr); end
    @(negedge clk); rfe = 0; spr_addr = 5'd5; #1;
    tests++; if (spr_rdata !== 32'h0) begin fails++; $display("FAIL mau_depth0 got %h exp 0", spr_rdata); end
  endtask

  task automatic test_if_err();
    @(negedge clk); if_pc = 32'h80; if_err = 1; #1;
    tests++; if ({id_flush, ex_flush} !== 2'b10) begin fails++; $display("FAIL iferr_flush got %b exp 10", {id_flush, ex_flush}); end
    tests++; if (new_pc !== 32'h120 || mode !== 4'd2) begin fails++; $display("FAIL iferr_pc got %h/%0d exp 120/2", new_pc, mode); end
    @(negedge clk); if_err = 0; spr_addr = 5'd1; #1;
    tests++; if (spr_rdata !== 32'h80) begin fails++; $display("FAIL iferr_epc got %h exp 80", spr_rdata); end
    @(negedge clk); rfe = 1; #1;
    tests++; if (new_pc !== 32'h80) begin fails++; $display("FAIL iferr_rfe got %h exp 80", new_pc); end
    @(negedge clk); rfe = 0;
  endtask

  task automatic test_busy_rfe_empty();
    @(negedge clk); wb_spr = 1; spr_addr = 5'd3; spr_wdata = 32'h01;
    @(negedge clk); wb_spr = 0; spr_addr = 5'd5; mau_busy = 1; irq = 8'h01; id_pc = 32'h500; #1;
    tests++; if ({if_halt, id_halt, ex_halt} !== 3'b111) begin fails++; $display("FAIL busy_halts got %b exp 111", {if_halt, id_halt, ex_halt}); end
    @(negedge clk); #1;
    tests++; if (set_pc !== 1'b0 || {if_halt, id_halt, ex_halt} !== 3'b111) begin fails++; $display("FAIL busy_block got %b/%b exp 0/111", set_pc, {if_halt, id_halt, ex_halt}); end
    @(negedge clk); mau_busy = 0; #1;
    tests++; if (set_pc !== 1'b1 || new_pc !== 32'h180) begin fails++; $display("FAIL busy_release got %b/%h exp 1/180", set_pc, new_pc); end
    tests++; if ({if_halt, id_halt, ex_halt} !== 3'b000) begin fails++; $display("FAIL busy_unhalt got %b exp 000", {if_halt, id_halt, ex_halt}); end
    @(negedge clk); irq = '0; #1;
    tests++; if (irq_ack !== 8'h01 || spr_rdata !== 32'h1) begin fails++; $display("FAIL busy_ack got %h/%h exp 01/1", irq_ack, spr_rdata); end
    @(negedge clk); rfe = 1; #1;
    tests++; if (new_pc !== 32'h500) begin fails++; $display("FAIL busy_rfe got %h exp 500", new_pc); end
    @(negedge clk); #1;
    tests++; if (set_pc !== 1'b1 || new_pc !== 32'h130 || mode !== 4'd3 || write_sr !== 1'b0) begin fails++; $display("FAIL rfe_empty got %b/%h/%0d/%b exp 1/130/3/0", set_pc, new_pc, mode, write_sr); end
    @(negedge clk); rfe = 0; #1;
    tests++; if (spr_rdata !== 32'h1) begin fails++; $display("FAIL rfe_empty_depth got %h exp 1", spr_rdata); end
    @(negedge clk); rfe = 1;
    @(negedge clk); rfe = 0; #1;
    tests++; if (spr_rdata !== 32'h0) begin fails++; $display("FAIL busy_depth0 got %h exp 0", spr_rdata); end
  endtask

  task automatic test_double_fault();
    sr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); swi = 1; id_pc = 32'h600 + 32'(4 * i); #1;
      tests++; if (new_pc !== 32'h110) begin fails++; $display("FAIL df_swi%0d got %h exp 110", i, new_pc); end
    end
    @(negedge clk); swi = 0; id_err = 1; spr_addr = 5'd5; #1;
    tests++; if (new_pc !== 32'h150 || mode !== 4'd5 || set_pc !== 1'b1) begin fails++; $display("FAIL df_vec got %h/%0d/%b exp 150/5/1", new_pc, mode, set_pc); end
    tests++; if (spr_rdata !== 32'h4) begin fails++; $display("FAIL df_depth got %h exp 4", spr_rdata); end
    @(negedge clk); id_err = 0; swi = 1; #1;
    tests++; if ({fatal, if_halt, id_halt, ex_halt} !== 4'b1111) begin fails++; $display("FAIL df_fatal got %b exp 1111", {fatal, if_halt, id_halt, ex_halt}); end
    tests++; if (set_pc !== 1'b0 || spr_rdata !== 32'h4) begin fails++; $display("FAIL df_ignore got %b/%h exp 0/4", set_pc, spr_rdata); end
    repeat (3) @(negedge clk);
    swi = 0; #1;
    tests++; if (fatal !== 1'b1) begin fails++; $display("FAIL df_stuck got %b exp 1", fatal); end
    #2; rst_n = 1'b0; #1;
    tests++; if ({fatal, if_halt, id_halt, ex_halt} !== 4'b0000 || spr_rdata !== 32'h0) begin fails++; $display("FAIL df_reset got %b/%h exp 0000/0", {fatal, if_halt, id_halt, ex_halt}, spr_rdata); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_irq_single();
    test_irq_nested();
    test_mau_swi();
    test_if_err();
    test_busy_rfe_empty();
    test_double_fault();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
